// File: rtl/botao_condicionador_pkg.sv
// Shared definitions for the pedestrian button conditioner: FSM encoding and default timings.
package botao_condicionador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  localparam int DEBOUNCE_DEF = 4;
  localparam int LOCKOUT_DEF  = 8;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/botao_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debounce on the raw button level.
module botao_debounce
  import botao_condicionador_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bt_raw,
  output logic pressed
);

  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] dcnt_q;
  logic [CNT_W-1:0] dcnt_d;

  // The counter only runs while the synchronised level disagrees with the stable one.
  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    if (s2_q != db_q) begin
      if (dcnt_q == DCNT_LAST) begin
        db_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      db_q   <= 1'b0;
      dcnt_q <= '0;
    end else begin
      s1_q   <= bt_raw;
      s2_q   <= s1_q;
      db_q   <= db_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign pressed = db_q;

endmodule

// File: rtl/botao_condicionador.sv
// Pedestrian button conditioner: debounce, rising-edge detect and a request/ack FSM
// with a post-service lockout. bt is a one-cycle pulse that feeds semaforo.bt.
module botao_condicionador
  import botao_condicionador_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int LOCKOUT  = LOCKOUT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bt_raw,
  input  logic ack,
  output logic bt,
  output logic req,
  output logic pressed
);

  localparam logic [CNT_W-1:0] LCNT_INIT = (LOCKOUT > 0) ? CNT_W'(LOCKOUT - 1) : '0;

  logic             db_prev_q;
  logic             press;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] lcnt_q;
  logic [CNT_W-1:0] lcnt_d;
  logic             bt_q;
  logic             bt_d;
  logic             req_q;
  logic             req_d;

  botao_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .bt_raw  (bt_raw),
    .pressed (pressed)
  );

  assign press = pressed & ~db_prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      db_prev_q <= 1'b0;
      state_q   <= ST_IDLE;
      lcnt_q    <= '0;
      bt_q      <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      db_prev_q <= pressed;
      state_q   <= state_d;
      lcnt_q    <= lcnt_d;
      bt_q      <= bt_d;
      req_q     <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (press) state_d = ST_PENDING;
      ST_PENDING: if (ack) state_d = (LOCKOUT > 0) ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT: if (lcnt_q == '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Ack takes priority over a press while pending, so a press there never pulses bt.
  always_comb begin
    bt_d   = 1'b0;
    req_d  = 1'b0;
    lcnt_d = lcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          bt_d  = 1'b1;
          req_d = 1'b1;
        end
      end
      ST_PENDING: begin
        req_d = ~ack;
        if (ack) lcnt_d = LCNT_INIT;
      end
      ST_LOCKOUT: begin
        if (lcnt_q != '0) lcnt_d = lcnt_q - CNT_W'(1);
      end
      default: begin
        lcnt_d = '0;
      end
    endcase
  end

  assign bt  = bt_q;
  assign req = req_q;

endmodule
